// File: rtl/cache_ram_arbiter_pkg.sv
// Shared state/op encodings and small helpers for the cache RAM arbiter.
package cache_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Successor of a requester index with wrap-around at num.
  function automatic int wrap_inc(input int idx, input int num);
    int nxt;
    nxt = idx + 32'sd1;
    return (nxt >= num) ? 32'sd0 : nxt;
  endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational rotating-priority picker: first pending bit at or above ptr, with wrap.
module cache_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  int cand_s;

  // Scan NUM_REQ candidates starting at ptr; the first pending one wins.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    cand_s = 32'sd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = int'(ptr) + k;
      cand_s = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
      if (!valid && pending[IDX_W'(cand_s)]) begin
        valid = 1'b1;
        index = IDX_W'(cand_s);
      end else begin
        valid = valid;
        index = index;
      end
    end
  end

endmodule

// File: rtl/cache_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between cache control units; holds each
// grant for a full transaction, latches the request, and aborts stalled RAM cycles.
module cache_ram_arbiter
  import cache_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          IN_CLK,
  input  logic                          IN_RESET,
  input  logic [NUM_REQ-1:0]            IN_REQ_RD,
  input  logic [NUM_REQ-1:0]            IN_REQ_WR,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] IN_REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] IN_REQ_WDATA,
  output logic [NUM_REQ-1:0]            OUT_REQ_ACK,
  output logic [DATA_WIDTH-1:0]         OUT_REQ_RDATA,
  output logic [NUM_REQ-1:0]            OUT_GRANT,
  output logic                          OUT_RAM_RD,
  output logic                          OUT_RAM_WR,
  output logic [ADDR_WIDTH-1:0]         OUT_RAM_ADDR,
  output logic [DATA_WIDTH-1:0]         OUT_RAM_WDATA,
  input  logic [DATA_WIDTH-1:0]         IN_RAM_RDATA,
  input  logic                          IN_RAM_ACK,
  output logic                          OUT_TIMEOUT
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0]   TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1'b1);

  state_t                  state_r,   state_s;
  logic [IDX_W-1:0]        ptr_r,     ptr_s;
  logic [IDX_W-1:0]        gidx_r,    gidx_s;
  op_t                     op_r,      op_s;
  logic [ADDR_WIDTH-1:0]   addr_r,    addr_s;
  logic [DATA_WIDTH-1:0]   wdata_r,   wdata_s;
  logic [CNT_W-1:0]        cnt_r,     cnt_s;
  logic [NUM_REQ-1:0]      grant_r,   grant_s;
  logic                    ram_rd_r,  ram_rd_s;
  logic                    ram_wr_r,  ram_wr_s;
  logic [NUM_REQ-1:0]      ack_r,     ack_s;
  logic [DATA_WIDTH-1:0]   rdata_r,   rdata_s;
  logic                    timeout_r, timeout_s;

  logic [NUM_REQ-1:0]      pending_s;
  logic                    pick_valid_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic [CNT_W-1:0]        cnt_inc_s;

  assign pending_s = IN_REQ_RD | IN_REQ_WR;

  cache_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pending (pending_s),
    .ptr     (ptr_r),
    .valid   (pick_valid_s),
    .index   (pick_idx_s)
  );

  // Next-state and next-output logic for the IDLE/BUSY/DONE transaction sequence.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    gidx_s    = gidx_r;
    op_s      = op_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    cnt_s     = cnt_r;
    grant_s   = grant_r;
    ram_rd_s  = ram_rd_r;
    ram_wr_s  = ram_wr_r;
    ack_s     = '0;
    rdata_s   = rdata_r;
    timeout_s = 1'b0;
    cnt_inc_s = cnt_r + CNT_ONE;

    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          // Read wins when a requester raises both strobes.
          state_s  = ST_BUSY;
          gidx_s   = pick_idx_s;
          op_s     = IN_REQ_RD[pick_idx_s] ? OP_RD : OP_WR;
          addr_s   = IN_REQ_ADDR[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_s  = IN_REQ_WDATA[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          cnt_s    = '0;
          grant_s  = GRANT_ONE << pick_idx_s;
          ram_rd_s = IN_REQ_RD[pick_idx_s];
          ram_wr_s = ~IN_REQ_RD[pick_idx_s];
        end else begin
          grant_s  = '0;
          ram_rd_s = 1'b0;
          ram_wr_s = 1'b0;
        end
      end

      ST_BUSY: begin
        if (IN_RAM_ACK) begin
          state_s  = ST_DONE;
          cnt_s    = cnt_inc_s;
          ram_rd_s = 1'b0;
          ram_wr_s = 1'b0;
          ack_s    = grant_r;
          rdata_s  = (op_r == OP_RD) ? IN_RAM_RDATA : '0;
        end else if (WDOG_EN && (cnt_inc_s == TIMEOUT_V)) begin
          state_s   = ST_DONE;
          cnt_s     = cnt_inc_s;
          ram_rd_s  = 1'b0;
          ram_wr_s  = 1'b0;
          ack_s     = grant_r;
          rdata_s   = '0;
          timeout_s = 1'b1;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end

      ST_DONE: begin
        state_s  = ST_IDLE;
        ptr_s    = IDX_W'(wrap_inc(int'(gidx_r), NUM_REQ));
        cnt_s    = '0;
        grant_s  = '0;
        ram_rd_s = 1'b0;
        ram_wr_s = 1'b0;
        rdata_s  = '0;
      end

      default: begin
        state_s  = ST_IDLE;
        cnt_s    = '0;
        grant_s  = '0;
        ram_rd_s = 1'b0;
        ram_wr_s = 1'b0;
        rdata_s  = '0;
      end
    endcase
  end

  // State, latches and registered outputs; async reset clears everything at once.
  always_ff @(posedge IN_CLK or posedge IN_RESET) begin
    if (IN_RESET) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      gidx_r    <= '0;
      op_r      <= OP_RD;
      addr_r    <= '0;
      wdata_r   <= '0;
      cnt_r     <= '0;
      grant_r   <= '0;
      ram_rd_r  <= 1'b0;
      ram_wr_r  <= 1'b0;
      ack_r     <= '0;
      rdata_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      gidx_r    <= gidx_s;
      op_r      <= op_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      cnt_r     <= cnt_s;
      grant_r   <= grant_s;
      ram_rd_r  <= ram_rd_s;
      ram_wr_r  <= ram_wr_s;
      ack_r     <= ack_s;
      rdata_r   <= rdata_s;
      timeout_r <= timeout_s;
    end
  end

  assign OUT_REQ_ACK   = ack_r;
  assign OUT_REQ_RDATA = rdata_r;
  assign OUT_GRANT     = grant_r;
  assign OUT_RAM_RD    = ram_rd_r;
  assign OUT_RAM_WR    = ram_wr_r;
  assign OUT_RAM_ADDR  = addr_r;
  assign OUT_RAM_WDATA = wdata_r;
  assign OUT_TIMEOUT   = timeout_r;

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Self-checking bench for cache_ram_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_cache_ram_arbiter;

  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic              IN_CLK;
  logic              IN_RESET;
  logic [NR-1:0]     req_rd, req_wr;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     ack, grant;
  logic [DW-1:0]     rdata, ram_wdata, ram_rdata;
  logic [AW-1:0]     ram_addr;
  logic              ram_rd, ram_wr, ram_ack, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  cache_ram_arbiter #(
    .NUM_REQ     (NR),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .IN_CLK        (IN_CLK),
    .IN_RESET      (IN_RESET),
    .IN_REQ_RD     (req_rd),
    .IN_REQ_WR     (req_wr),
    .IN_REQ_ADDR   (req_addr),
    .IN_REQ_WDATA  (req_wdata),
    .OUT_REQ_ACK   (ack),
    .OUT_REQ_RDATA (rdata),
    .OUT_GRANT     (grant),
    .OUT_RAM_RD    (ram_rd),
    .OUT_RAM_WR    (ram_wr),
    .OUT_RAM_ADDR  (ram_addr),
    .OUT_RAM_WDATA (ram_wdata),
    .IN_RAM_RDATA  (ram_rdata),
    .IN_RAM_ACK    (ram_ack),
    .OUT_TIMEOUT   (timeout)
  );

  initial IN_CLK = 1'b0;
  always #5 IN_CLK = ~IN_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  // Round-robin rule: first pending requester at or after ptr, wrapping.
  function automatic int model_pick(input logic [NR-1:0] pend, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (pend[2'((ptr + k) % NR)]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int idx);
    logic [NR-1:0] one;
    one = 3'b001;
    return one << idx;
  endfunction

  task automatic tick();
    @(posedge IN_CLK);
    #1;
  endtask

  // Advance until a RAM strobe appears; waited = edges taken, -1 if none within bound.
  task automatic wait_busy(output int waited);
    waited = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      waited++;
      if (ram_rd || ram_wr) break;
    end
    if (!(ram_rd || ram_wr)) waited = -1;
  endtask

  // Act as the RAM from BUSY cycle 1: ack during cycle ack_cyc (0 = never); stops at the ack pulse.
  task automatic serve(input int ack_cyc, input logic [DW-1:0] data,
                       output logic [NR-1:0] o_ack, output logic [DW-1:0] o_rdata,
                       output logic o_to, output logic [NR-1:0] o_grant, output int strobes);
    strobes = 0;
    o_ack = '0; o_rdata = '0; o_to = 1'b0; o_grant = '0;
    for (int c = 1; c <= 12; c++) begin
      if (ram_rd || ram_wr) strobes++;
      ram_rdata = (c == ack_cyc) ? data : $urandom();
      ram_ack   = (c == ack_cyc);
      tick();
      ram_ack = 1'b0;
      if (ack != '0) begin
        o_ack = ack; o_rdata = rdata; o_to = timeout; o_grant = grant;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    ram_rdata = '0; ram_ack = 1'b0;
    IN_RESET = 1'b0;
    #2 IN_RESET = 1'b1;
    tick(); tick();
    n_checks++;
    if ({grant, ack, ram_rd, ram_wr, timeout} !== '0)
      begin n_fail++; $display("FAIL reset_ctrl: got %b required 0", {grant, ack, ram_rd, ram_wr, timeout}); end
    n_checks++;
    if ({ram_addr, ram_wdata, rdata} !== '0)
      begin n_fail++; $display("FAIL reset_data: got %h required 0", {ram_addr, ram_wdata, rdata}); end
    IN_RESET = 1'b0;
    m_ptr = 0;
    tick();
    n_checks++;
    if ({grant, ram_rd, ram_wr} !== '0)
      begin n_fail++; $display("FAIL idle_after_reset: got %b required 0", {grant, ram_rd, ram_wr}); end
  endtask

  task automatic test_single_read();
    int w, st; logic [NR-1:0] oa, og; logic [DW-1:0] od; logic ot;
    req_addr[0*AW +: AW] = 16'h0040;
    req_rd[0] = 1'b1;
    wait_busy(w);
    n_checks++;
    if (w !== 1) begin n_fail++; $display("FAIL rd_latency: got %0d edges required 1", w); end
    n_checks++;
    if ({grant, ram_rd, ram_wr, ram_addr} !== {3'b001, 1'b1, 1'b0, 16'h0040})
      begin n_fail++; $display("FAIL rd_start: got %b/%b%b/%h required 001/10/0040", grant, ram_rd, ram_wr, ram_addr); end
    serve(3, 32'hDEADBEEF, oa, od, ot, og, st);
    req_rd[0] = 1'b0;
    n_checks++;
    if (st !== 3) begin n_fail++; $display("FAIL rd_strobe_len: got %0d required 3", st); end
    n_checks++;
    if ({oa, od, ot, og} !== {3'b001, 32'hDEADBEEF, 1'b0, 3'b001})
      begin n_fail++; $display("FAIL rd_done: got ack %b data %h to %b grant %b required 001 deadbeef 0 001", oa, od, ot, og); end
    n_checks++;
    if ({ram_rd, ram_wr} !== 2'b00) begin n_fail++; $display("FAIL rd_done_strobe: got %b%b required 00", ram_rd, ram_wr); end
    tick();
    n_checks++;
    if ({grant, ack} !== 6'b0) begin n_fail++; $display("FAIL rd_end: got grant %b ack %b required 0", grant, ack); end
    m_ptr = 1;
  endtask

  task automatic test_stray_ack();
    ram_ack = 1'b1;
    ram_rdata = 32'h1234_5678;
    tick();
    ram_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({grant, ack, ram_rd, ram_wr, timeout, rdata, ram_addr} !== {9'b0, 32'h0, 16'h0040})
        begin n_fail++; $display("FAIL stray_ack: got grant %b ack %b rdata %h addr %h required quiet", grant, ack, rdata, ram_addr); end
      tick();
    end
  endtask

  task automatic test_stable_latch();
    int w, st; logic [NR-1:0] oa, og; logic [DW-1:0] od; logic ot;
    req_addr[1*AW +: AW] = 16'h0010;
    req_rd[1] = 1'b1;
    wait_busy(w);
    n_checks++;
    if ({grant, ram_addr} !== {3'b010, 16'h0010})
      begin n_fail++; $display("FAIL latch_start: got %b/%h required 010/0010", grant, ram_addr); end
    req_addr[1*AW +: AW] = 16'h0020;
    req_rd[1] = 1'b0;
    req_wr[1] = 1'b1;
    tick();
    n_checks++;
    if ({grant, ram_rd, ram_wr, ram_addr} !== {3'b010, 1'b1, 1'b0, 16'h0010})
      begin n_fail++; $display("FAIL latch_hold: got %b/%b%b/%h required 010/10/0010", grant, ram_rd, ram_wr, ram_addr); end
    serve(1, 32'hA5A5_0F0F, oa, od, ot, og, st);
    req_wr[1] = 1'b0;
    n_checks++;
    if ({oa, od} !== {3'b010, 32'hA5A5_0F0F})
      begin n_fail++; $display("FAIL latch_done: got %b/%h required 010/a5a50f0f", oa, od); end
    m_ptr = 2;
    tick();
  endtask

  task automatic test_timeout();
    int w, st; logic [NR-1:0] oa, og; logic [DW-1:0] od, wd; logic ot;
    wd = $urandom();
    req_wdata[2*DW +: DW] = wd;
    req_wr[2] = 1'b1;
    wait_busy(w);
    n_checks++;
    if ({grant, ram_wr, ram_wdata} !== {3'b100, 1'b1, wd})
      begin n_fail++; $display("FAIL to_start: got %b/%b/%h required 100/1/%h", grant, ram_wr, ram_wdata, wd); end
    serve(0, 32'hFFFF_FFFF, oa, od, ot, og, st);
    req_wr[2] = 1'b0;
    n_checks++;
    if ({oa, od, ot, st} !== {3'b100, 32'h0, 1'b1, 32'd4})
      begin n_fail++; $display("FAIL to_abort: got ack %b data %h to %b busy %0d required 100 0 1 4", oa, od, ot, st); end
    tick();
    n_checks++;
    if ({timeout, ack} !== 4'b0) begin n_fail++; $display("FAIL to_pulse: got to %b ack %b required 0", timeout, ack); end
    m_ptr = 0;
    wd = $urandom();
    req_rd[0] = 1'b1;
    wait_busy(w);
    serve(4, wd, oa, od, ot, og, st);
    req_rd[0] = 1'b0;
    n_checks++;
    if ({oa, od, ot, st} !== {3'b001, wd, 1'b0, 32'd4})
      begin n_fail++; $display("FAIL to_ack_wins: got ack %b data %h to %b busy %0d required 001 %h 0 4", oa, od, ot, st, wd); end
    m_ptr = 1;
    tick();
  endtask

  task automatic test_contention();
    int w, st; logic [NR-1:0] oa, og; logic [DW-1:0] od, d; logic ot;
    IN_RESET = 1'b1;
    req_addr = {16'h3333, 16'h2222, 16'h1111};
    req_wr = 3'b001;
    req_rd = 3'b010;
    tick();
    IN_RESET = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 6; i++) begin
      wait_busy(w);
      if (i > 0) begin
        n_checks++;
        if (w !== 2) begin n_fail++; $display("FAIL b2b_gap: got %0d edges required 2", w); end
      end
      n_checks++;
      if ({grant, ram_rd, ram_wr, ram_addr} !== {onehot(i % 2), (i % 2 == 1), (i % 2 == 0), ((i % 2 == 1) ? 16'h2222 : 16'h1111)})
        begin n_fail++; $display("FAIL contention_%0d: got %b/%b%b/%h", i, grant, ram_rd, ram_wr, ram_addr); end
      d = $urandom();
      serve(int'($urandom_range(1, 3)), d, oa, od, ot, og, st);
      n_checks++;
      if ({oa, od, ot} !== {onehot(i % 2), ((i % 2 == 1) ? d : 32'h0), 1'b0})
        begin n_fail++; $display("FAIL contention_done_%0d: got %b/%h/%b required %b", i, oa, od, ot, onehot(i % 2)); end
    end
    m_ptr = 2;
    req_rd = '0; req_wr = '0;
    tick();
  endtask

  task automatic test_fairness();
    int w, st, g; int cnt [NR]; logic [NR-1:0] oa, og; logic [DW-1:0] od; logic ot;
    for (int k = 0; k < NR; k++) cnt[k] = 0;
    req_rd = 3'($urandom());
    req_wr = ~req_rd;
    for (int i = 0; i < 3 * NR; i++) begin
      wait_busy(w);
      g = model_pick(3'b111, m_ptr);
      n_checks++;
      if (grant !== onehot(g)) begin n_fail++; $display("FAIL fair_grant_%0d: got %b required %b", i, grant, onehot(g)); end
      for (int k = 0; k < NR; k++) if (grant[2'(k)]) cnt[k]++;
      serve(int'($urandom_range(1, 3)), $urandom(), oa, od, ot, og, st);
      m_ptr = (g + 1) % NR;
    end
    for (int k = 0; k < NR; k++) begin
      n_checks++;
      if (cnt[k] !== 3) begin n_fail++; $display("FAIL fair_count_%0d: got %0d required 3", k, cnt[k]); end
    end
    req_rd = '0; req_wr = '0;
    tick();
  endtask

  task automatic test_random();
    int w, st, g, dly; logic [1:0] gi; logic [NR-1:0] oa, og, r, wr; logic [DW-1:0] od, d; logic ot, exp_to;
    for (int i = 0; i < 24; i++) begin
      r  = 3'($urandom());
      wr = 3'($urandom());
      if ((r | wr) == 3'b000) r = onehot(int'($urandom_range(0, NR - 1)));
      req_rd = r; req_wr = wr;
      req_addr = 48'({$urandom(), $urandom()});
      req_wdata = {$urandom(), $urandom(), $urandom()};
      wait_busy(w);
      n_checks++;
      if (w < 0) begin n_fail++; $display("FAIL rnd_no_grant_%0d: no strobe within bound", i); end
      g  = model_pick(r | wr, m_ptr);
      gi = 2'(g);
      n_checks++;
      if ({grant, ram_rd, ram_wr, ram_addr, ram_wdata} !==
          {onehot(g), r[gi], ~r[gi], req_addr[int'(gi)*AW +: AW], req_wdata[int'(gi)*DW +: DW]})
        begin n_fail++; $display("FAIL rnd_start_%0d: got %b/%b%b/%h/%h required grant %b", i, grant, ram_rd, ram_wr, ram_addr, ram_wdata, onehot(g)); end
      dly = int'($urandom_range(1, 6));
      d = $urandom();
      exp_to = (dly > TO);
      serve(dly, d, oa, od, ot, og, st);
      n_checks++;
      if ({oa, od, ot} !== {onehot(g), ((!exp_to && r[gi]) ? d : 32'h0), exp_to})
        begin n_fail++; $display("FAIL rnd_done_%0d: got %b/%h/%b required %b/%h/%b", i, oa, od, ot, onehot(g), ((!exp_to && r[gi]) ? d : 32'h0), exp_to); end
      m_ptr = (g + 1) % NR;
    end
    req_rd = '0; req_wr = '0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int w, st, g; logic [NR-1:0] oa, og; logic [DW-1:0] od, d; logic ot;
    req_rd = 3'b001;
    wait_busy(w);
    g = model_pick(3'b001, m_ptr);
    serve(1, $urandom(), oa, od, ot, og, st);
    m_ptr = (g + 1) % NR;
    req_rd = 3'b010;
    wait_busy(w);
    n_checks++;
    if (grant !== 3'b010) begin n_fail++; $display("FAIL rst_pre_grant: got %b required 010", grant); end
    tick();
    #3 IN_RESET = 1'b1;
    #1;
    n_checks++;
    if ({grant, ack, ram_rd, ram_wr, timeout} !== '0)
      begin n_fail++; $display("FAIL rst_async_drop: got %b required 0", {grant, ack, ram_rd, ram_wr, timeout}); end
    req_rd = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (ack !== 3'b000) begin n_fail++; $display("FAIL rst_no_ack: got %b required 000", ack); end
    end
    IN_RESET = 1'b0;
    m_ptr = 0;
    req_rd = 3'b011;
    wait_busy(w);
    n_checks++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL rst_ptr_zero: got %b required 001", grant); end
    d = $urandom();
    serve(2, d, oa, od, ot, og, st);
    req_rd = '0;
    n_checks++;
    if ({oa, od} !== {3'b001, d}) begin n_fail++; $display("FAIL rst_after_txn: got %b/%h required 001/%h", oa, od, d); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_stray_ack();
    test_stable_latch();
    test_timeout();
    test_contention();
    test_fairness();
    test_random();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
